// File: rtl/genius_uc_param_if.sv
// Game-side bundle of the Genius control unit: start/level/buttons in,
// sequence memory read port, LED drive and end-of-game status.
interface genius_uc_param_if #(
  parameter int N_BTN   = 4,
  parameter int ADDR_W  = 4,
  parameter int LIVES_W = 2
);
  logic              iniciar;
  logic [1:0]        nivel;
  logic [N_BTN-1:0]  botoes;
  logic [N_BTN-1:0]  mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [N_BTN-1:0]  leds;
  logic [ADDR_W:0]   rodada;
  logic [LIVES_W-1:0] vidas;
  logic              pronto;
  logic              acertou;
  logic              errou;
  logic              fim_timeout;
  logic [3:0]        db_estado;

  modport master (
    input  iniciar, nivel, botoes, mem_data,
    output mem_addr, leds, rodada, vidas, pronto, acertou, errou, fim_timeout, db_estado
  );

  modport slave (
    output iniciar, nivel, botoes, mem_data,
    input  mem_addr, leds, rodada, vidas, pronto, acertou, errou, fim_timeout, db_estado
  );
endinterface

// File: rtl/genius_uc_param.sv
// Genius (Simon) control unit with configurable buttons, per-level target length
// and an optional lives/retry mechanism enabled by the GENIUS_LIVES_EN macro.
module genius_uc_param #(
  parameter int N_BTN       = 4,
  parameter int ADDR_W      = 4,
  parameter int SHOW_CYC    = 500,
  parameter int GAP_CYC     = 500,
  parameter int TIMEOUT_CYC = 5000,
  parameter int LIVES       = 3
) (
  input  logic clock,
  input  logic reset,
  genius_uc_param_if.master bus
);

  localparam int TMR_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int LIVES_W = $clog2(LIVES + 1);

  typedef enum logic [3:0] {
    S_INICIAL       = 4'h0,
    S_PREPARA       = 4'h1,
    S_PROX_MOSTRA   = 4'h2,
    S_ESPERA        = 4'h3,
    S_REGISTRA      = 4'h4,
    S_COMPARA       = 4'h5,
    S_PROX_JOGADA   = 4'h6,
    S_FIM_RODADA    = 4'h7,
    S_PROX_SEQ      = 4'h8,
    S_MOSTRA        = 4'h9,
    S_INTERVALO     = 4'hA,
    S_INICIA_SEQ    = 4'hB,
    S_PERDE_VIDA    = 4'hC,
    S_FINAL_TIMEOUT = 4'hD,
    S_FINAL_ACERTOU = 4'hE,
    S_FINAL_ERROU   = 4'hF
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  limit_q, limit_d;
  logic [ADDR_W:0]    target_q, target_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [N_BTN-1:0]   play_q, play_d;
  logic [N_BTN-1:0]   btn_prev_q, btn_prev_d;
  logic               cause_tmo_q, cause_tmo_d;
  logic [LIVES_W-1:0] vidas_q, vidas_d;

  logic            jogada;
  logic            play_onehot;
  logic            match;
  logic            show_done;
  logic            gap_done;
  logic            tmo_done;
  logic            addr_last;
  logic            last_round;
  logic [ADDR_W:0] lvl_len;

  assign jogada      = (btn_prev_q == '0) && (bus.botoes != '0);
  assign play_onehot = (play_q != '0) && ((play_q & (play_q - N_BTN'(1))) == '0);
  assign match       = play_onehot && (play_q == bus.mem_data);
  assign show_done   = (timer_q == TMR_W'(SHOW_CYC - 1));
  assign gap_done    = (timer_q == TMR_W'(GAP_CYC - 1));
  assign tmo_done    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign addr_last   = (addr_q == limit_q);
  assign last_round  = ((ADDR_W+1)'(limit_q) == (target_q - (ADDR_W+1)'(1)));
  assign lvl_len     = (ADDR_W+1)'(bus.nivel) + (ADDR_W+1)'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INICIAL;
      addr_q      <= '0;
      limit_q     <= '0;
      target_q    <= '0;
      timer_q     <= '0;
      tmo_q       <= '0;
      play_q      <= '0;
      btn_prev_q  <= '0;
      cause_tmo_q <= 1'b0;
      vidas_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      limit_q     <= limit_d;
      target_q    <= target_d;
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      play_q      <= play_d;
      btn_prev_q  <= btn_prev_d;
      cause_tmo_q <= cause_tmo_d;
      vidas_q     <= vidas_d;
    end
  end

  // The show/gap timer restarts from zero whenever a timed state is left,
  // so each timed state always starts counting at 0.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    limit_d     = limit_q;
    target_d    = target_q;
    timer_d     = '0;
    tmo_d       = tmo_q;
    play_d      = play_q;
    btn_prev_d  = bus.botoes;
    cause_tmo_d = cause_tmo_q;
    vidas_d     = vidas_q;
    case (state_q)
      S_INICIAL: begin
        if (bus.iniciar) state_d = S_PREPARA;
      end
      S_PREPARA: begin
        addr_d   = '0;
        limit_d  = '0;
        tmo_d    = '0;
        target_d = lvl_len << (ADDR_W - 2);
`ifdef GENIUS_LIVES_EN
        vidas_d  = LIVES_W'(LIVES);
`endif
        state_d  = S_MOSTRA;
      end
      S_MOSTRA: begin
        if (show_done) state_d = S_INTERVALO;
        else           timer_d = timer_q + TMR_W'(1);
      end
      S_INTERVALO: begin
        if (gap_done) state_d = S_PROX_MOSTRA;
        else          timer_d = timer_q + TMR_W'(1);
      end
      S_PROX_MOSTRA: begin
        if (addr_last) begin
          state_d = S_INICIA_SEQ;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_MOSTRA;
        end
      end
      S_INICIA_SEQ: begin
        addr_d  = '0;
        tmo_d   = '0;
        state_d = S_ESPERA;
      end
      S_ESPERA: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (jogada) begin
          state_d = S_REGISTRA;
        end else if (tmo_done) begin
          cause_tmo_d = 1'b1;
          state_d     = S_PERDE_VIDA;
        end
      end
      S_REGISTRA: begin
        play_d  = bus.botoes;
        state_d = S_COMPARA;
      end
      S_COMPARA: begin
        if (match) begin
          state_d = addr_last ? S_FIM_RODADA : S_PROX_JOGADA;
        end else begin
          cause_tmo_d = 1'b0;
          state_d     = S_PERDE_VIDA;
        end
      end
      S_PROX_JOGADA: begin
        addr_d  = addr_q + ADDR_W'(1);
        tmo_d   = '0;
        state_d = S_ESPERA;
      end
      S_FIM_RODADA: begin
        if (last_round)    state_d = S_FINAL_ACERTOU;
        else if (gap_done) state_d = S_PROX_SEQ;
        else               timer_d = timer_q + TMR_W'(1);
      end
      S_PROX_SEQ: begin
        limit_d = limit_q + ADDR_W'(1);
        addr_d  = '0;
        state_d = S_MOSTRA;
      end
      S_PERDE_VIDA: begin
`ifdef GENIUS_LIVES_EN
        // Entry cycle is recognised by the timer still being at zero.
        if (timer_q == '0 && vidas_q == LIVES_W'(1)) begin
          vidas_d = '0;
          state_d = cause_tmo_q ? S_FINAL_TIMEOUT : S_FINAL_ERROU;
        end else begin
          if (timer_q == '0) vidas_d = vidas_q - LIVES_W'(1);
          if (gap_done) begin
            addr_d  = '0;
            state_d = S_MOSTRA;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
`else
        state_d = cause_tmo_q ? S_FINAL_TIMEOUT : S_FINAL_ERROU;
`endif
      end
      S_FINAL_TIMEOUT, S_FINAL_ACERTOU, S_FINAL_ERROU: begin
        if (bus.iniciar) state_d = S_PREPARA;
      end
      default: state_d = S_INICIAL;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.vidas     = vidas_q;
  assign bus.db_estado = state_q;

  always_comb begin
    bus.leds        = '0;
    bus.rodada      = (ADDR_W+1)'(limit_q) + (ADDR_W+1)'(1);
    bus.pronto      = 1'b0;
    bus.acertou     = 1'b0;
    bus.errou       = 1'b0;
    bus.fim_timeout = 1'b0;
    case (state_q)
      S_INICIAL:       bus.rodada = '0;
      S_MOSTRA:        bus.leds = bus.mem_data;
      S_ESPERA:        bus.leds = bus.botoes;
      S_FINAL_TIMEOUT: begin
        bus.pronto      = 1'b1;
        bus.fim_timeout = 1'b1;
      end
      S_FINAL_ACERTOU: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      S_FINAL_ERROU: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_genius_uc_param.sv
// Directed bench for genius_uc_param: full win, short win, wrong plays, timeout,
// held buttons and asynchronous reset; lives expectations follow GENIUS_LIVES_EN.
module tb_genius_uc_param;

  localparam int N_BTN       = 4;
  localparam int ADDR_W      = 2;
  localparam int SHOW_CYC    = 2;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 10;
  localparam int LIVES       = 2;
  localparam int LIVES_W     = $clog2(LIVES + 1);
`ifdef GENIUS_LIVES_EN
  localparam int FULL_LIVES  = LIVES;
`else
  localparam int FULL_LIVES  = 0;
`endif

  localparam logic [3:0] S_INICIAL = 4'h0, S_PREPARA = 4'h1, S_PROX_MOSTRA = 4'h2,
                         S_ESPERA = 4'h3, S_REGISTRA = 4'h4, S_COMPARA = 4'h5,
                         S_PROX_JOGADA = 4'h6, S_FIM_RODADA = 4'h7, S_PROX_SEQ = 4'h8,
                         S_MOSTRA = 4'h9, S_INTERVALO = 4'hA, S_INICIA_SEQ = 4'hB,
                         S_PERDE_VIDA = 4'hC, S_FINAL_TIMEOUT = 4'hD,
                         S_FINAL_ACERTOU = 4'hE, S_FINAL_ERROU = 4'hF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N_BTN-1:0] mem [0:3];
  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  genius_uc_param_if #(.N_BTN(N_BTN), .ADDR_W(ADDR_W), .LIVES_W(LIVES_W)) bus ();

  assign bus.mem_data = mem[bus.mem_addr];

  genius_uc_param #(
    .N_BTN(N_BTN), .ADDR_W(ADDR_W), .SHOW_CYC(SHOW_CYC), .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .LIVES(LIVES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ini, input logic [1:0] lvl, input logic [N_BTN-1:0] btn);
    bus.iniciar = ini;
    bus.nivel   = lvl;
    bus.botoes  = btn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Enters PREPARA from INICIAL or a final state, then lands in MOSTRA.
  task automatic startGame(input logic [1:0] lvl);
    applyStimulus(1'b1, lvl, '0);
    tick();
    checkOutput("start_prepara", bus.db_estado, S_PREPARA);
    bus.iniciar = 1'b0;
    tick();
  endtask

  // Display of a round of n items, ending in ESPERA.
  task automatic showRound(input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput("show_state", bus.db_estado, S_MOSTRA);
      checkOutput("show_leds", bus.leds, mem[k]);
      checkOutput("show_rodada", bus.rodada, n);
      tick();
      checkOutput("show_state2", bus.db_estado, S_MOSTRA);
      checkOutput("show_leds2", bus.leds, mem[k]);
      tick();
      checkOutput("gap_state", bus.db_estado, S_INTERVALO);
      checkOutput("gap_leds", bus.leds, 0);
      tick();
      checkOutput("gap_state2", bus.db_estado, S_INTERVALO);
      tick();
      checkOutput("prox_mostra", bus.db_estado, S_PROX_MOSTRA);
      tick();
    end
    checkOutput("inicia_seq", bus.db_estado, S_INICIA_SEQ);
    tick();
    checkOutput("espera_entry", bus.db_estado, S_ESPERA);
  endtask

  // One play from ESPERA; returns with the state that follows COMPARA.
  task automatic press(input logic [N_BTN-1:0] val, input bit hold);
    checkOutput("press_espera", bus.db_estado, S_ESPERA);
    bus.botoes = val;
    #1;
    checkOutput("espera_leds", bus.leds, val);
    tick();
    checkOutput("registra", bus.db_estado, S_REGISTRA);
    tick();
    checkOutput("compara", bus.db_estado, S_COMPARA);
    if (!hold) bus.botoes = '0;
    tick();
  endtask

  // Correct plays for a round of n items; continues into the next MOSTRA
  // or stops in FINAL_ACERTOU when last is set.
  task automatic playRound(input int n, input bit last);
    for (int k = 0; k < n; k++) begin
      press(mem[k], 1'b0);
      if (k < n - 1) begin
        checkOutput("prox_jogada", bus.db_estado, S_PROX_JOGADA);
        tick();
      end else begin
        checkOutput("fim_rodada", bus.db_estado, S_FIM_RODADA);
      end
    end
    tick();
    if (last) begin
      checkOutput("final_acertou", bus.db_estado, S_FINAL_ACERTOU);
    end else begin
      checkOutput("fim_rodada_gap", bus.db_estado, S_FIM_RODADA);
      tick();
      checkOutput("prox_seq", bus.db_estado, S_PROX_SEQ);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;
    applyStimulus(1'b0, 2'b00, '0);

    #12;
    checkOutput("reset_state", bus.db_estado, S_INICIAL);
    checkOutput("reset_leds", bus.leds, 0);
    checkOutput("reset_rodada", bus.rodada, 0);
    checkOutput("reset_vidas", bus.vidas, 0);
    checkOutput("reset_pronto", bus.pronto, 0);
    checkOutput("reset_addr", bus.mem_addr, 0);
    reset = 1'b1;
    tick();
    checkOutput("idle_state", bus.db_estado, S_INICIAL);

    $display("[TB] full game, level 3");
    startGame(2'b11);
    checkOutput("start_vidas", bus.vidas, FULL_LIVES);
    showRound(1);
    bus.iniciar = 1'b1;
    tick();
    checkOutput("iniciar_ignored", bus.db_estado, S_ESPERA);
    bus.iniciar = 1'b0;
    playRound(1, 1'b0);
    showRound(2);
    repeat (9) tick();
    checkOutput("press_at_expiry_pre", bus.db_estado, S_ESPERA);
    playRound(2, 1'b0);
    showRound(3);
    playRound(3, 1'b0);
    showRound(4);
    playRound(4, 1'b1);
    checkOutput("win_acertou", bus.acertou, 1);
    checkOutput("win_pronto", bus.pronto, 1);
    checkOutput("win_errou", bus.errou, 0);
    checkOutput("win_rodada", bus.rodada, 4);
    checkOutput("win_leds", bus.leds, 0);

    $display("[TB] short game, level 0");
    startGame(2'b00);
    showRound(1);
    playRound(1, 1'b1);
    checkOutput("short_rodada", bus.rodada, 1);
    checkOutput("short_acertou", bus.acertou, 1);

    $display("[TB] wrong play in round 2");
    startGame(2'b11);
    showRound(1);
    playRound(1, 1'b0);
    showRound(2);
    press(mem[0], 1'b1);
    checkOutput("held_prox_jogada", bus.db_estado, S_PROX_JOGADA);
    tick();
    tick();
    checkOutput("held_no_jogada", bus.db_estado, S_ESPERA);
    tick();
    checkOutput("held_no_jogada2", bus.db_estado, S_ESPERA);
    bus.botoes = '0;
    tick();
    press(4'b0100, 1'b0);
    checkOutput("wrong_perde_vida", bus.db_estado, S_PERDE_VIDA);
    checkOutput("wrong_pronto", bus.pronto, 0);
`ifdef GENIUS_LIVES_EN
    checkOutput("wrong_vidas_entry", bus.vidas, 2);
    tick();
    checkOutput("wrong_perde_vida2", bus.db_estado, S_PERDE_VIDA);
    checkOutput("wrong_vidas_after", bus.vidas, 1);
    tick();
    showRound(2);
    press(4'b0100, 1'b0);
    checkOutput("wrong2_perde_vida", bus.db_estado, S_PERDE_VIDA);
`endif
    tick();
    checkOutput("final_errou", bus.db_estado, S_FINAL_ERROU);
    checkOutput("errou_flag", bus.errou, 1);
    checkOutput("errou_pronto", bus.pronto, 1);
    checkOutput("errou_acertou", bus.acertou, 0);
    checkOutput("errou_vidas", bus.vidas, 0);
    checkOutput("errou_rodada", bus.rodada, 2);

    $display("[TB] restart from FINAL_ERROU, then timeout");
    startGame(2'b11);
    checkOutput("restart_vidas", bus.vidas, FULL_LIVES);
    checkOutput("restart_rodada", bus.rodada, 1);
    showRound(1);
    repeat (9) tick();
    checkOutput("timeout_pre", bus.db_estado, S_ESPERA);
    tick();
    checkOutput("timeout_exact", bus.db_estado, S_PERDE_VIDA);
`ifdef GENIUS_LIVES_EN
    tick();
    tick();
    showRound(1);
    repeat (10) tick();
    checkOutput("timeout2_exact", bus.db_estado, S_PERDE_VIDA);
`endif
    tick();
    checkOutput("final_timeout", bus.db_estado, S_FINAL_TIMEOUT);
    checkOutput("timeout_flag", bus.fim_timeout, 1);
    checkOutput("timeout_pronto", bus.pronto, 1);
    checkOutput("timeout_errou", bus.errou, 0);
    checkOutput("timeout_vidas", bus.vidas, 0);

    $display("[TB] asynchronous reset during round 3 display");
    startGame(2'b11);
    showRound(1);
    playRound(1, 1'b0);
    showRound(2);
    playRound(2, 1'b0);
    checkOutput("r3_mostra", bus.db_estado, S_MOSTRA);
    checkOutput("r3_rodada", bus.rodada, 3);
    reset = 1'b0;
    #2;
    checkOutput("async_state", bus.db_estado, S_INICIAL);
    checkOutput("async_leds", bus.leds, 0);
    checkOutput("async_rodada", bus.rodada, 0);
    checkOutput("async_addr", bus.mem_addr, 0);
    checkOutput("async_vidas", bus.vidas, 0);
    checkOutput("async_pronto", bus.pronto, 0);
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", bus.db_estado, S_INICIAL);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/genius_uc_param.md
Name: genius_uc_param

Overview:
- Parametrised next-generation control unit for the Genius (Simon) memory game.
- Owns the game's address counter, round-limit counter, show/gap timers, timeout timer and button edge detection internally.
- Adds a configurable button count, a selectable target length per difficulty level, and a lives/retry mechanism.
- Sits between the sequence memory (read port), the button inputs and the LED/status outputs of the game top level.

Parameters:
N_BTN, 4, number of buttons/LEDs; memory words are one-hot N_BTN bits
ADDR_W, 4, sequence address width; max sequence length 2^ADDR_W; must be >= 2
SHOW_CYC, 500, cycles an LED stays lit during sequence display
GAP_CYC, 500, cycles of dark gap between shown items and between rounds
TIMEOUT_CYC, 5000, cycles allowed per play before timeout
LIVES, 3, lives per game (used only with GENIUS_LIVES_EN); must be >= 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start / restart request (level-sampled)
nivel  in  2  difficulty, sampled in PREPARA; target length = (nivel+1) << (ADDR_W-2)
botoes  in  N_BTN  raw synchronised buttons
mem_data  in  N_BTN  sequence memory word at mem_addr (combinational read)
mem_addr  out  ADDR_W  sequence address
leds  out  N_BTN  LED drive
rodada  out  ADDR_W+1  current round length (limit+1); 0 in INICIAL
vidas  out  clog2(LIVES+1)  remaining lives
pronto, acertou, errou, fim_timeout  out  1 each  end-of-game flags
db_estado  out  4  current state code

Behaviour:
- Reset (reset=0, asynchronous): state INICIAL; all counters 0; every output 0.
- State codes: INICIAL 0, PREPARA 1, PROX_MOSTRA 2, ESPERA 3, REGISTRA 4, COMPARA 5, PROX_JOGADA 6, FIM_RODADA 7, PROX_SEQ 8, MOSTRA 9, INTERVALO A, INICIA_SEQ B, PERDE_VIDA C, FINAL_TIMEOUT D, FINAL_ACERTOU E, FINAL_ERROU F.
- Outputs are Moore: registered state, combinational decode.
- INICIAL: go to PREPARA when iniciar=1.
- PREPARA (1 cycle):
  - addr=0, limit=0, timers=0.
  - Latch target from nivel; vidas=LIVES.
  - Then go to MOSTRA.
- MOSTRA: leds=mem_data for SHOW_CYC cycles, then INTERVALO.
- INTERVALO: leds=0 for GAP_CYC cycles, then PROX_MOSTRA.
- PROX_MOSTRA (1 cycle):
  - If addr==limit, go to INICIA_SEQ.
  - Otherwise addr++ and go to MOSTRA.
- INICIA_SEQ (1 cycle): addr=0, timeout timer=0, then ESPERA.
- Play detection: jogada = registered botoes was all-zero and current botoes is nonzero.
- ESPERA:
  - leds=botoes; timeout timer increments.
  - jogada, go to REGISTRA. jogada has priority over timeout in the same cycle.
  - Else if timer==TIMEOUT_CYC-1, record cause=timeout and go to PERDE_VIDA.
- REGISTRA (1 cycle): capture botoes into the play register.
- COMPARA: a match requires the play register to equal mem_data exactly; a non-one-hot play is a mismatch.
  - Match and addr<limit: go to PROX_JOGADA.
  - Match and addr==limit: go to FIM_RODADA.
  - Mismatch: record cause=error and go to PERDE_VIDA.
- PROX_JOGADA (1 cycle): addr++, timeout timer=0, then ESPERA.
- FIM_RODADA:
  - If limit==target-1, go to FINAL_ACERTOU.
  - Otherwise wait GAP_CYC cycles, then PROX_SEQ.
- PROX_SEQ (1 cycle): limit++, addr=0, then MOSTRA.
  - limit never exceeds 2^ADDR_W-1, because target <= 2^ADDR_W.
- PERDE_VIDA:
  - On entry cycle, vidas decrements.
  - If vidas was 1 on entry, go to FINAL_TIMEOUT or FINAL_ERROU according to cause.
  - Otherwise wait GAP_CYC cycles, set addr=0, and go to MOSTRA. This replays the same round; limit is unchanged.
- Final states:
  - pronto=1, plus exactly one of acertou, errou or fim_timeout.
  - leds=0; rodada holds its last value.
  - iniciar=1 goes to PREPARA.
- iniciar is ignored in every state except INICIAL and the final states.
- A reset pulse mid-game returns immediately to INICIAL with all outputs 0.
- rodada = limit+1 in every state except INICIAL.

Optional Feature:
- Macro: GENIUS_LIVES_EN.
- Defined: lives mechanism exactly as in Behaviour.
- Undefined:
  - PERDE_VIDA goes directly to the final state matching the cause after 1 cycle.
  - vidas is tied to 0 and LIVES is ignored.
  - Behaviour is equivalent to a single-life game.

Test Plan:
All scenarios use N_BTN=4, ADDR_W=2, SHOW_CYC=2, GAP_CYC=2, TIMEOUT_CYC=10, LIVES=2, with memory loaded 0001, 0010, 0100, 1000.
1. nivel=11, iniciar, all plays correct -> shows rounds of 1,2,3,4 items (leds pattern verified each), then FINAL_ACERTOU (db_estado=E), acertou=1, pronto=1, rodada=4.
2. nivel=00, iniciar, press 0001 -> FINAL_ACERTOU after round 1, rodada=1.
3. nivel=11 with macro defined, round 2, wrong second play 0100 -> PERDE_VIDA (C), vidas=1, round 2 replayed (same 2 items); second wrong play -> FINAL_ERROU, errou=1, vidas=0.
4. Macro defined, no press in ESPERA -> PERDE_VIDA exactly 10 cycles after entry; repeat -> FINAL_TIMEOUT, fim_timeout=1. Press on cycle 10 (same cycle as expiry) -> REGISTRA instead.
5. Macro undefined, single wrong play -> FINAL_ERROU directly, vidas=0 throughout; held button produces only one jogada.
6. Drive reset=0 during MOSTRA of round 3 -> state 0 asynchronously, all outputs 0; iniciar during ESPERA ignored; iniciar in FINAL_ERROU -> PREPARA, vidas=2, rodada=1.
